// File: rtl/frame_serializer.sv
// Parallel-to-serial framer: MSB-first serial output with a frame-sync pulse, continuous framing.
// Optional build macro FRAME_SERIALIZER_IDLE_REPEAT_EN: on underrun, resend the last frame instead of zeros.
module frame_serializer #(
   parameter int FRAME_W = 256,
   parameter int CNT_W   = 16
) (
   input  logic               sclk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [FRAME_W-1:0] in_data,
   output logic               in_ready,
   output logic               sdata,
   output logic               sfs,
   output logic               underrun,
   output logic [CNT_W-1:0]   underrun_cnt
);

   localparam int BC_W = $clog2(FRAME_W);

   typedef enum logic {STOP, RUN} state_t;

   state_t             state, state_nxt;
   logic [FRAME_W-1:0] hold;
   logic [FRAME_W-1:0] shreg;
   logic [FRAME_W-1:0] next_frame;
   logic               hold_full;
   logic [BC_W-1:0]    bitcnt;
   logic               load;
   logic               take_hold;
   logic               accept;
`ifdef FRAME_SERIALIZER_IDLE_REPEAT_EN
   logic [FRAME_W-1:0] last_frame;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign in_ready = !hold_full && !rst;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge sclk) begin
      if (rst) state <= STOP;
      else     state <= state_nxt;
   end

   // A frame loads on the first edge after data arrives in STOP, then on every frame boundary in RUN.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      take_hold = 1'b0;
      case (state)
         STOP: begin
            if (hold_full) begin
               load      = 1'b1;
               take_hold = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (bitcnt == BC_W'(FRAME_W - 1)) begin
               load      = 1'b1;
               take_hold = hold_full;
            end
         end
         default: state_nxt = STOP;
      endcase
   end

   always_comb begin
      next_frame = '0;
      if (take_hold) next_frame = hold;
`ifdef FRAME_SERIALIZER_IDLE_REPEAT_EN
      else next_frame = last_frame;
`endif
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         hold_full    <= 1'b0;
         bitcnt       <= '0;
         sdata        <= 1'b0;
         sfs          <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         if (accept)         hold_full <= 1'b1;
         else if (take_hold) hold_full <= 1'b0;

         if (load) begin
            sdata    <= next_frame[FRAME_W-1];
            sfs      <= 1'b1;
            bitcnt   <= '0;
            underrun <= !take_hold;
            if (!take_hold) underrun_cnt <= sat_inc(underrun_cnt);
         end else if (state == RUN) begin
            sdata    <= shreg[FRAME_W-1];
            sfs      <= 1'b0;
            bitcnt   <= bitcnt + BC_W'(1);
            underrun <= 1'b0;
         end else begin
            sdata    <= 1'b0;
            sfs      <= 1'b0;
            underrun <= 1'b0;
         end
      end
   end

`ifdef FRAME_SERIALIZER_IDLE_REPEAT_EN
   always_ff @(posedge sclk) begin
      if (rst)            last_frame <= '0;
      else if (take_hold) last_frame <= hold;
   end
`endif

   // Data registers carry no reset; hold_full and the FSM decide what is valid.
   always_ff @(posedge sclk) begin
      if (accept) hold <= in_data;
      if (load) shreg <= {next_frame[FRAME_W-2:0], 1'b0};
      else      shreg <= {shreg[FRAME_W-2:0], 1'b0};
   end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer (FRAME_W=16, CNT_W=2): vector table plus multi-cycle sequences.
module tb_frame_serializer;

   localparam int FW = 16;
   localparam int CW = 2;
`ifdef FRAME_SERIALIZER_IDLE_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic          sclk;
   logic          rst;
   logic          in_valid;
   logic [FW-1:0] in_data;
   logic          in_ready;
   logic          sdata;
   logic          sfs;
   logic          underrun;
   logic [CW-1:0] underrun_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int stray = 0;

   typedef struct {
      logic [FW-1:0] data;
      logic          und;
      logic [CW-1:0] cnt;
      int            start;
   } rec_t;

   typedef struct {
      logic [FW-1:0] data;
      logic          exp_und;
      logic [CW-1:0] exp_cnt;
   } vec_t;

   rec_t frames_q[$];
   vec_t vecs[6];

   frame_serializer #(.FRAME_W(FW), .CNT_W(CW)) dut (
      .sclk         (sclk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .sdata        (sdata),
      .sfs          (sfs),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   initial forever begin
      @(posedge sclk);
      cyc++;
   end

   // Frame monitor: rebuilds each frame from sfs/sdata and records flags seen at its first bit.
   initial begin : monitor
      int            pos;
      logic [FW-1:0] cur;
      rec_t          rec;
      pos = 0;
      cur = '0;
      forever begin
         @(negedge sclk);
         if (rst) begin
            pos = 0;
         end else if (sfs) begin
            cur       = {{(FW-1){1'b0}}, sdata};
            pos       = 1;
            rec.und   = underrun;
            rec.cnt   = underrun_cnt;
            rec.start = cyc;
         end else if (pos > 0) begin
            cur = {cur[FW-2:0], sdata};
            pos++;
         end
         if (pos == FW) begin
            rec.data = cur;
            frames_q.push_back(rec);
            pos = 0;
         end
         if (underrun && !sfs && !rst) stray++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] idle_of(input logic [FW-1:0] last);
      return REP ? last : '0;
   endfunction

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge sclk);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (4) @(negedge sclk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_sdata", sdata, 0);
      chk("rst_sfs", sfs, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_cnt", underrun_cnt, 0);
      rst = 1'b0;
      frames_q.delete();
      @(negedge sclk);
      chk("post_rst_in_ready", in_ready, 1);
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send(input logic [FW-1:0] d, output int hs);
      int n;
      n        = 0;
      hs       = -1;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 4 * FW) begin
         @(negedge sclk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready low for %0d cycles, expected high", n);
         in_valid = 1'b0;
      end else begin
         hs = cyc;
         @(negedge sclk);
         in_valid = 1'b0;
      end
   endtask

   task automatic get_rec(output rec_t r);
      int n;
      n       = 0;
      r.data  = '0;
      r.und   = 1'b0;
      r.cnt   = '0;
      r.start = -1;
      while (frames_q.size() == 0 && n < 4 * FW) begin
         @(negedge sclk);
         n++;
      end
      if (frames_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL frame_timeout: no frame after %0d cycles, expected one", n);
      end else begin
         r = frames_q.pop_front();
      end
   endtask

   initial begin : main
      rec_t r, r0;
      int   hs, hs2, hs3, s, s2, prev, nsfs;

      vecs[0] = '{data: 16'h0000, exp_und: 1'b0, exp_cnt: 2'd0};
      vecs[1] = '{data: 16'hFFFF, exp_und: 1'b0, exp_cnt: 2'd0};
      vecs[2] = '{data: 16'hA5A5, exp_und: 1'b0, exp_cnt: 2'd0};
      vecs[3] = '{data: 16'h0001, exp_und: 1'b0, exp_cnt: 2'd0};
      vecs[4] = '{data: 16'h8000, exp_und: 1'b0, exp_cnt: 2'd0};
      vecs[5] = '{data: 16'h1234, exp_und: 1'b0, exp_cnt: 2'd0};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      @(negedge sclk);

      // Cold start, then one underrun frame
      do_reset();
      send(16'h8001, hs);
      get_rec(r);
      chk("cold_start_cycle", r.start, hs + 2);
      chk("cold_data", r.data, 16'h8001);
      chk("cold_und", r.und, 0);
      chk("cold_cnt", r.cnt, 0);
      get_rec(r0);
      chk("idle_period", r0.start, r.start + FW);
      chk("idle_und", r0.und, 1);
      chk("idle_cnt", r0.cnt, 1);
      chk("idle_data", r0.data, idle_of(16'h8001));

      // Streaming from the vector table
      do_reset();
      for (int i = 0; i < 6; i++) send(vecs[i].data, hs);
      prev = -1;
      for (int i = 0; i < 6; i++) begin
         get_rec(r);
         chk($sformatf("stream_data_%0d", i), r.data, vecs[i].data);
         chk($sformatf("stream_und_%0d", i), r.und, vecs[i].exp_und);
         chk($sformatf("stream_cnt_%0d", i), r.cnt, vecs[i].exp_cnt);
         if (i > 0) chk($sformatf("stream_period_%0d", i), r.start, prev + FW);
         prev = r.start;
      end

      // Late frame at the boundary edge, then a just-in-time frame
      do_reset();
      send(16'hC3C3, hs);
      s = hs + 2;
      wait_until(s + FW - 1);
      send(16'h5A5A, hs2);
      chk("late_hs", hs2, s + FW - 1);
      get_rec(r);
      chk("late_a_start", r.start, s);
      chk("late_a_data", r.data, 16'hC3C3);
      get_rec(r);
      chk("late_idle_start", r.start, s + FW);
      chk("late_idle_und", r.und, 1);
      chk("late_idle_cnt", r.cnt, 1);
      chk("late_idle_data", r.data, idle_of(16'hC3C3));
      s2 = s + 2 * FW;
      wait_until(s2 + FW - 2);
      send(16'h0F0F, hs3);
      chk("jit_hs", hs3, s2 + FW - 2);
      get_rec(r);
      chk("late_b_start", r.start, s2);
      chk("late_b_data", r.data, 16'h5A5A);
      chk("late_b_und", r.und, 0);
      chk("late_b_cnt", r.cnt, 1);
      get_rec(r);
      chk("jit_start", r.start, s2 + FW);
      chk("jit_data", r.data, 16'h0F0F);
      chk("jit_und", r.und, 0);
      chk("jit_cnt", r.cnt, 1);

      // Backpressure while the holding register is full
      do_reset();
      send(16'h1111, hs);
      s = hs + 2;
      send(16'h2222, hs2);
      chk("bp_b_hs", hs2, s);
      chk("bp_ready_low", in_ready, 0);
      send(16'h3333, hs3);
      chk("bp_c_hs", hs3, s + FW);
      get_rec(r);
      chk("bp_a_data", r.data, 16'h1111);
      chk("bp_a_start", r.start, s);
      get_rec(r);
      chk("bp_b_data", r.data, 16'h2222);
      chk("bp_b_start", r.start, s + FW);
      chk("bp_b_und", r.und, 0);
      get_rec(r);
      chk("bp_c_data", r.data, 16'h3333);
      chk("bp_c_start", r.start, s + 2 * FW);
      chk("bp_c_und", r.und, 0);
      get_rec(r);
      chk("bp_idle_start", r.start, s + 3 * FW);
      chk("bp_idle_und", r.und, 1);
      chk("bp_idle_cnt", r.cnt, 1);

      // Counter saturation under starvation
      do_reset();
      send(16'h0FF0, hs);
      get_rec(r);
      chk("sat_a_data", r.data, 16'h0FF0);
      prev = r.start;
      for (int i = 1; i <= 6; i++) begin
         get_rec(r);
         chk($sformatf("sat_und_%0d", i), r.und, 1);
         chk($sformatf("sat_cnt_%0d", i), r.cnt, (i < 3) ? i : 3);
         chk($sformatf("sat_data_%0d", i), r.data, idle_of(16'h0FF0));
         chk($sformatf("sat_period_%0d", i), r.start, prev + FW);
         prev = r.start;
      end

      // Reset in the middle of a frame (do_reset also checks the counter clears)
      do_reset();
      send(16'hFFFF, hs);
      s = hs + 2;
      wait_until(s + 10);
      chk("mid_sdata_before", sdata, 1);
      rst = 1'b1;
      @(negedge sclk);
      chk("mid_rst_sdata", sdata, 0);
      chk("mid_rst_sfs", sfs, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_underrun", underrun, 0);
      @(negedge sclk);
      rst = 1'b0;
      frames_q.delete();
      nsfs = 0;
      repeat (3 * FW) begin
         @(negedge sclk);
         if (sfs) nsfs++;
      end
      chk("mid_no_sfs", nsfs, 0);
      send(16'h9009, hs);
      get_rec(r);
      chk("mid_restart_start", r.start, hs + 2);
      chk("mid_restart_data", r.data, 16'h9009);
      chk("mid_restart_und", r.und, 0);
      chk("mid_restart_cnt", r.cnt, 0);

      chk("stray_underrun", stray, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
